// File: rtl/c432_key_pkg.sv
// c432_key_pkg: shared widths, FSM state type and key bundle layout for the
// c432 key loader.
//   KEY_W  total key bits (MUX_W + XOR_W)
//   MUX_W  mux-select key bits p1..p4, packed in the low bits
//   XOR_W  XOR key bits X_1..X_11, packed above the mux bits
package c432_key_pkg;

  localparam int MUX_W = 4;
  localparam int XOR_W = 11;
  localparam int KEY_W = MUX_W + XOR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Packed so that p lands at [MUX_W-1:0] and x at [KEY_W-1:MUX_W].
  typedef struct packed {
    logic [XOR_W-1:0] x;
    logic [MUX_W-1:0] p;
  } key_t;

  // Even parity over key plus parity bit: a nonzero result is a bad frame.
  function automatic logic parity_fail(input logic run_par, input logic par_bit);
    return run_par ^ par_bit;
  endfunction

endpackage

// File: rtl/c432_key_shreg.sv
// c432_key_shreg: bit-serial key shift register with bit counter and running
// parity for the c432 key loader.
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   clr       clear counter, parity and data for a new frame
//   shift_en  store bit_in at position cnt, fold it into parity, advance cnt
//   bit_in    serial key bit
//   data      assembled key bits
//   cnt       number of bits stored so far in this frame
//   par       XOR of all bits stored so far in this frame
module c432_key_shreg
  import c432_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             par
);

  // Shift/count/parity state; clear has priority over shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
      par  <= 1'b0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
      par  <= 1'b0;
    end else if (shift_en) begin
      data[cnt] <= bit_in;
      cnt       <= cnt + 4'd1;
      par       <= par ^ bit_in;
    end
  end

endmodule

// File: rtl/c432_key_loader.sv
// c432_key_loader: receives the 15-bit c432 unlock key LSB first over a
// valid/ready bit-serial link, checks it with a trailing even-parity bit and
// holds the last good key on key_o for the locked core.
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset (clears the committed key too)
//   load_start  pulse: start a frame (restarts a frame already in progress)
//   key_valid   key_bit is valid this cycle
//   key_bit     serial key data, p1 first, parity bit last
//   key_ready   high while a frame accepts bits (SHIFT or PARITY)
//   key_o       committed key {X_11..X_1, p4..p1}
//   key_ok      a good key has been committed
//   key_err     sticky: the last frame failed parity
//   busy        a frame is in progress
// Build option: define C432_KEY_WRITE_ONCE_EN to lock the key after its first
// commit; further load_start pulses are then ignored until reset.
module c432_key_loader
  import c432_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_o,
  output logic             key_ok,
  output logic             key_err,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W - 1);

  state_t           state_r;
  key_t             key_r;
  logic             key_ok_r;
  logic             key_err_r;
  logic             start_allowed_s;
  logic             key_ready_s;
  logic             hs_s;
  logic             clr_s;
  logic             shift_en_s;
  logic [KEY_W-1:0] data_s;
  logic [CNT_W-1:0] cnt_s;
  logic             par_s;

`ifdef C432_KEY_WRITE_ONCE_EN
  logic locked_r;

  // Lock flag: set by the first commit, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_r <= 1'b0;
    end else if (state_r == COMMIT) begin
      locked_r <= 1'b1;
    end
  end

  assign start_allowed_s = ~locked_r;
`else
  assign start_allowed_s = 1'b1;
`endif

  assign key_ready_s = (state_r == SHIFT) || (state_r == PARITY);
  assign hs_s        = key_valid && key_ready_s;

  // Shift-register control: a start (or restart) clears, a SHIFT handshake stores.
  always_comb begin
    clr_s      = 1'b0;
    shift_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        clr_s = load_start && start_allowed_s;
      end
      SHIFT, PARITY: begin
        if (load_start) begin
          clr_s = 1'b1;
        end else begin
          shift_en_s = hs_s && (state_r == SHIFT);
        end
      end
      default: begin
        clr_s      = 1'b0;
        shift_en_s = 1'b0;
      end
    endcase
  end

  c432_key_shreg u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_s),
    .shift_en (shift_en_s),
    .bit_in   (key_bit),
    .data     (data_s),
    .cnt      (cnt_s),
    .par      (par_s)
  );

  // Frame FSM with registered key, ok and error outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      key_r     <= '0;
      key_ok_r  <= 1'b0;
      key_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_start && start_allowed_s) begin
            state_r   <= SHIFT;
            key_err_r <= 1'b0;
          end
        end
        SHIFT: begin
          // A restart keeps us in SHIFT; the shift register clears itself.
          if (!load_start && hs_s && (cnt_s == LAST_CNT)) begin
            state_r <= PARITY;
          end
        end
        PARITY: begin
          if (load_start) begin
            state_r <= SHIFT;
          end else if (hs_s) begin
            if (parity_fail(par_s, key_bit)) begin
              key_err_r <= 1'b1;
              state_r   <= IDLE;
            end else begin
              state_r <= COMMIT;
            end
          end
        end
        COMMIT: begin
          key_r    <= key_t'(data_s);
          key_ok_r <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign key_ready = key_ready_s;
  assign key_o     = key_r;
  assign key_ok    = key_ok_r;
  assign key_err   = key_err_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: doc/c432_key_loader.md
# c432_key_loader

Serial key-delivery block for the key-locked c432 benchmark core. It receives the 15-bit unlock key over a valid/ready bit-serial link and checks it with an even-parity bit. On a good frame it drives the key bundle (4 mux-select bits plus 11 XOR-key bits) into the locked core. It is the supplier end of the core's key inputs: the core only consumes the key, and this block produces and holds it.

## Interface
- KEY_W, 15: total key bits; must equal MUX_W + XOR_W.
- MUX_W, 4: mux-select key bits, packed at key_o[3:0] as p1..p4.
- XOR_W, 11: XOR key bits, packed at key_o[14:4] as X_1..X_11.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- load_start  in  1  one-cycle pulse that starts a new frame.
- key_valid  in  1  key_bit is valid this cycle.
- key_bit  in  1  serial key data, LSB (p1) first; the parity bit follows the last key bit.
- key_ready  out  1  loader accepts a bit this cycle.
- key_o  out  KEY_W  committed key, held stable between commits.
- key_ok  out  1  a good key is committed.
- key_err  out  1  sticky: the last frame failed parity.
- busy  out  1  a frame is in progress.

## Operation
- States:
  - IDLE: waits for load_start.
  - SHIFT: accepts bits and counts them 0..KEY_W-1.
  - PARITY: accepts one parity bit.
  - COMMIT: one cycle, updates the outputs.
- IDLE -> SHIFT on load_start. In the same edge the bit counter and running parity clear, and key_err clears.
- SHIFT: each handshake (key_valid && key_ready) shifts key_bit into position cnt, XORs it into the running parity, and increments cnt. The handshake with cnt==KEY_W-1 moves to PARITY.
- PARITY: the handshake evaluates running parity ^ key_bit.
  - Result 0 goes to COMMIT.
  - Result 1 sets key_err and returns to IDLE; key_o and key_ok are unchanged.
- COMMIT: key_o <= shift register, key_ok <= 1, then IDLE.
- key_o is never updated from a partial or bad frame. The last good key persists across failed loads.
- load_start during SHIFT or PARITY aborts the frame and restarts it: the counter and parity clear, and that cycle's bit is discarded. load_start during COMMIT is ignored.
- key_valid in IDLE or COMMIT is ignored.
- busy = (state != IDLE).

## Timing
- Reset values: key_o = 0, key_ok = 0, key_err = 0, key_ready = 0, busy = 0, state = IDLE.
- Reset mid-frame discards everything, including a previously committed key.
- key_ready = 1 exactly in SHIFT and PARITY; it is combinational from state only.
- Minimum frame: 1 start cycle + 16 handshake cycles + 1 COMMIT cycle.
- key_o and key_ok change on the edge that ends COMMIT. They are first visible 2 cycles after the parity handshake edge.
- key_err is visible 1 cycle after a failing parity handshake edge.
- Gaps (key_valid low) are allowed anywhere in a frame; there is no timeout.

## Configuration
- C432_KEY_WRITE_ONCE_EN defined:
  - After the first commit, load_start is ignored until reset, and key_ready stays 0.
  - key_err cannot be set after commit.
- C432_KEY_WRITE_ONCE_EN undefined: the key can be reloaded any number of times, as described above.

## Structure
- Package c432_key_pkg holds:
  - KEY_W, MUX_W and XOR_W localparams.
  - The state enum (IDLE, SHIFT, PARITY, COMMIT).
  - A packed struct key_t {logic [XOR_W-1:0] x; logic [MUX_W-1:0] p;}.
- Sub-module c432_key_shreg: the shift register plus counter plus running parity, with clear and shift-enable inputs and data, count and parity outputs. The FSM stays in c432_key_loader.

## Test plan
- Reset, then send key 15'h5A3C (LSB first) with parity bit 0 (the key has eight 1s). Required: key_o = 15'h5A3C and key_ok = 1 two cycles after the parity handshake; key_err = 0.
- Same key with parity bit 1. Required: key_err = 1 one cycle later, key_ok = 0, key_o = 0.
- Commit 15'h0001 (parity bit 1), then send a bad frame for 15'h7FFF (parity bit 0). Required: key_o remains 15'h0001, key_err = 1, key_ok = 1.
- Pulse load_start after 7 bits of a frame, then send a full frame for 15'h1234 (parity bit 1) with random key_valid gaps. Required: key_o = 15'h1234.
- Reset pulse asserted during PARITY. Required: all outputs 0 on the next cycle and state IDLE.
- With C432_KEY_WRITE_ONCE_EN defined, commit 15'h0F0F (parity bit 0), then pulse load_start. Required: busy stays 0, key_ready stays 0, key_o = 15'h0F0F.
